// File: rtl/branch_predictor_param.sv
// Branch-direction predictor: a table of saturating counters indexed by PC
// (bimodal) or by PC XOR global history (gshare). Predictions are returned one
// cycle after a request is accepted. Resolved branches from execute train the
// table. After reset, a sweep writes the initial counter value into every
// entry, so the table itself has no reset flops.
module branch_predictor_param #(
  parameter int PHT_SIZE  = 2048,
  parameter int CTR_BITS  = 2,
  parameter int HIST_BITS = 11,
  parameter int MODE      = 0,
  parameter int PC_LSB    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_val,
  output logic                 req_rdy,
  input  logic [31:0]          req_pc,
  output logic                 resp_val,
  output logic                 resp_taken,
  output logic [HIST_BITS-1:0] resp_hist,
  input  logic                 update_en,
  input  logic [31:0]          update_pc,
  input  logic [HIST_BITS-1:0] update_hist,
  input  logic                 update_taken,
  output logic                 init_busy
);

  localparam int IDX_BITS = $clog2(PHT_SIZE);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // The initial value is weakly-not-taken: the MSB is clear and all lower bits are set.
  localparam int                   WNT_INT  = (1 << (CTR_BITS - 1)) - 1;
  localparam logic [CTR_BITS-1:0]  CTR_WNT  = WNT_INT[CTR_BITS-1:0];
  localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
  localparam logic [IDX_BITS-1:0]  LAST_IDX = IDX_BITS'(PHT_SIZE - 1);
  localparam bit                   USE_HIST = (MODE == 1);

  logic [0:0]           state_q, state_d;
  logic [IDX_BITS-1:0]  init_ptr_q, init_ptr_d;
  logic [HIST_BITS-1:0] ghr_q, ghr_d, ghr_shift;
  logic                 resp_val_q, resp_taken_q;
  logic [HIST_BITS-1:0] resp_hist_q;
  logic [CTR_BITS-1:0]  pht_q [PHT_SIZE];

  logic                 ready;
  logic                 accept;
  logic [IDX_BITS-1:0]  pred_hist_ext, upd_hist_ext;
  logic [IDX_BITS-1:0]  pred_idx, upd_idx;
  logic [CTR_BITS-1:0]  pred_ctr, upd_ctr, upd_ctr_d;
  logic                 unused_pc_bits;

  assign ready     = (state_q == ST_READY);
  assign accept    = req_val && ready;
  assign req_rdy   = ready;
  assign init_busy = !ready;

  // Bimodal mode drops the history term, so only the PC slice selects the entry.
  assign pred_hist_ext = IDX_BITS'(ghr_q);
  assign upd_hist_ext  = IDX_BITS'(update_hist);
  assign pred_idx = req_pc[PC_LSB +: IDX_BITS]    ^ (USE_HIST ? pred_hist_ext : '0);
  assign upd_idx  = update_pc[PC_LSB +: IDX_BITS] ^ (USE_HIST ? upd_hist_ext  : '0);

  assign pred_ctr = pht_q[pred_idx];
  assign upd_ctr  = pht_q[upd_idx];

  // PC bits outside the index slice are intentionally ignored.
  assign unused_pc_bits = ^{req_pc, update_pc};

  // The newest outcome enters at bit 0. A one-bit history holds only the newest outcome.
  generate
    if (HIST_BITS == 1) begin : g_ghr_one
      assign ghr_shift = update_taken;
    end else begin : g_ghr_multi
      assign ghr_shift = {ghr_q[HIST_BITS-2:0], update_taken};
    end
  endgenerate

  // Compute the saturating counter step for the entry being trained.
  always_comb begin
    upd_ctr_d = upd_ctr;
    if (update_taken) begin
      if (upd_ctr != CTR_MAX) upd_ctr_d = upd_ctr + CTR_BITS'(1);
    end else begin
      if (upd_ctr != '0) upd_ctr_d = upd_ctr - CTR_BITS'(1);
    end
  end

  // Next-state logic: the sweep pointer advances through INIT, and the history shifts only when READY.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    ghr_d      = ghr_q;
    if (state_q == ST_INIT) begin
      init_ptr_d = init_ptr_q + IDX_BITS'(1);
      if (init_ptr_q == LAST_IDX) state_d = ST_READY;
    end else if (update_en) begin
      ghr_d = ghr_shift;
    end
  end

  // Control, history and response registers. Reset drops any in-flight response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      init_ptr_q   <= '0;
      ghr_q        <= '0;
      resp_val_q   <= 1'b0;
      resp_taken_q <= 1'b0;
      resp_hist_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      ghr_q      <= ghr_d;
      resp_val_q <= accept;
      if (accept) begin
        resp_taken_q <= pred_ctr[CTR_BITS-1];
        resp_hist_q  <= ghr_q;
      end
    end
  end

  // Table write port: the sweep writes the initial value, and READY applies training updates.
  // The read paths above are combinational, so the prediction sees the pre-update value.
  always_ff @(posedge clk) begin
    if (!ready) begin
      pht_q[init_ptr_q] <= CTR_WNT;
    end else if (update_en) begin
      pht_q[upd_idx] <= upd_ctr_d;
    end
  end

  assign resp_val   = resp_val_q;
  assign resp_taken = resp_taken_q;
  assign resp_hist  = resp_hist_q;

endmodule

// File: tb/tb_branch_predictor_param.sv
// Bench for branch_predictor_param. A bimodal instance and a gshare instance
// share one set of inputs. A behavioural model tracks counters, history and
// expected responses, and both instances are compared against it every cycle.
// Literal expectations pin the model at the key points.
module tb_branch_predictor_param;

  localparam int PHT = 16;
  localparam int HB  = 4;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        reqVal = 1'b0;
  logic [31:0] reqPc = '0;
  logic        updEn = 1'b0;
  logic [31:0] updPc = '0;
  logic [3:0]  updHist = '0;
  logic        updTaken = 1'b0;

  logic        bReqRdy, bRespVal, bRespTaken, bInitBusy;
  logic [3:0]  bRespHist;
  logic        gReqRdy, gRespVal, gRespTaken, gInitBusy;
  logic [3:0]  gRespHist;

  int testsRun  = 0;
  int failCount = 0;
  bit checkEn   = 1'b0;

  int phtB [PHT];
  int phtG [PHT];
  int modelGhr   = 0;
  int initLeft   = PHT;
  int expHist    = 0;
  bit expRespVal = 1'b0;
  bit expTakenB  = 1'b0;
  bit expTakenG  = 1'b0;

  // Free-running clock with a period of 10 time units.
  always #5 clk = ~clk;

  branch_predictor_param #(.PHT_SIZE(PHT), .CTR_BITS(2), .HIST_BITS(HB), .MODE(0), .PC_LSB(2)) dutBim (
    .clk(clk), .reset(rstN), .req_val(reqVal), .req_rdy(bReqRdy), .req_pc(reqPc),
    .resp_val(bRespVal), .resp_taken(bRespTaken), .resp_hist(bRespHist),
    .update_en(updEn), .update_pc(updPc), .update_hist(updHist), .update_taken(updTaken),
    .init_busy(bInitBusy));

  branch_predictor_param #(.PHT_SIZE(PHT), .CTR_BITS(2), .HIST_BITS(HB), .MODE(1), .PC_LSB(2)) dutGs (
    .clk(clk), .reset(rstN), .req_val(reqVal), .req_rdy(gReqRdy), .req_pc(reqPc),
    .resp_val(gRespVal), .resp_taken(gRespTaken), .resp_hist(gRespHist),
    .update_en(updEn), .update_pc(updPc), .update_hist(updHist), .update_taken(updTaken),
    .init_busy(gInitBusy));

  function automatic int idxOf(input int pc, input int hist, input bit gshare);
    return ((pc >> 2) ^ (gshare ? hist : 0)) % PHT;
  endfunction

  function automatic int satStep(input int ctr, input bit taken);
    if (taken) return (ctr < 3) ? ctr + 1 : 3;
    return (ctr > 0) ? ctr - 1 : 0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit rv, input logic [31:0] rpc, input bit ue,
                               input logic [31:0] upc, input logic [3:0] uh, input bit ut);
    @(negedge clk);
    #1;
    reqVal   = rv;
    reqPc    = rpc;
    updEn    = ue;
    updPc    = upc;
    updHist  = uh;
    updTaken = ut;
  endtask

  // Model: reset restarts a countdown. When the countdown expires, the whole table holds WNT.
  // While READY, a request reads the counter before the same-edge update is applied.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      initLeft   = PHT;
      modelGhr   = 0;
      expRespVal = 1'b0;
      expTakenB  = 1'b0;
      expTakenG  = 1'b0;
      expHist    = 0;
    end else if (initLeft > 0) begin
      initLeft--;
      expRespVal = 1'b0;
      if (initLeft == 0) begin
        for (int i = 0; i < PHT; i++) begin
          phtB[i] = 1;
          phtG[i] = 1;
        end
      end
    end else begin
      expRespVal = reqVal;
      if (reqVal) begin
        expTakenB = phtB[idxOf(int'(reqPc), modelGhr, 1'b0)] >= 2;
        expTakenG = phtG[idxOf(int'(reqPc), modelGhr, 1'b1)] >= 2;
        expHist   = modelGhr;
      end
      if (updEn) begin
        phtB[idxOf(int'(updPc), int'(updHist), 1'b0)] = satStep(phtB[idxOf(int'(updPc), int'(updHist), 1'b0)], updTaken);
        phtG[idxOf(int'(updPc), int'(updHist), 1'b1)] = satStep(phtG[idxOf(int'(updPc), int'(updHist), 1'b1)], updTaken);
        modelGhr = ((modelGhr << 1) | int'(updTaken)) % (1 << HB);
      end
    end
  end

  // On every falling edge, compare both instances against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("bimBusy",  bInitBusy,  int'(initLeft != 0));
      checkOutput("gsBusy",   gInitBusy,  int'(initLeft != 0));
      checkOutput("bimRdy",   bReqRdy,    int'(initLeft == 0));
      checkOutput("gsRdy",    gReqRdy,    int'(initLeft == 0));
      checkOutput("bimVal",   bRespVal,   expRespVal);
      checkOutput("gsVal",    gRespVal,   expRespVal);
      checkOutput("bimTaken", bRespTaken, expTakenB);
      checkOutput("gsTaken",  gRespTaken, expTakenG);
      checkOutput("bimHist",  bRespHist,  expHist);
      checkOutput("gsHist",   gRespHist,  expHist);
    end
  end

  // Directed sequence: init sweep, saturation, history shift, gshare aliasing, same-edge access, and mid-run reset.
  initial begin
    int cnt;
    for (int i = 0; i < PHT; i++) begin
      phtB[i] = 1;
      phtG[i] = 1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkEn = 1'b1;
    checkOutput("rstRespVal", bRespVal, 0);
    checkOutput("rstBusy", bInitBusy, 1);
    checkOutput("rstRdy", gReqRdy, 0);
    checkOutput("rstHist", gRespHist, 0);

    // Requests and updates are driven throughout the sweep and must be ignored.
    rstN = 1'b1;
    cnt = 0;
    while (bInitBusy && cnt < 40) begin
      applyStimulus(1, 32'h100, 1, 32'h100, 4'h0, 1);
      cnt++;
    end
    reqVal = 1'b0;
    updEn  = 1'b0;
    checkOutput("initCycles", cnt, 16);

    applyStimulus(1, 32'h100, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("postInitVal", bRespVal, 1);
    checkOutput("postInitTaken", bRespTaken, 0);
    checkOutput("postInitGhr", gRespHist, 0);
    checkOutput("modelWnt", phtB[0], 1);

    // Saturation at the top, then the walk down, then no wrap below zero.
    repeat (4) applyStimulus(0, 0, 1, 32'h100, 4'h0, 1);
    applyStimulus(1, 32'h100, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("sat3Taken", bRespTaken, 1);
    checkOutput("modelSat3", phtB[0], 3);
    applyStimulus(0, 0, 1, 32'h100, 4'h0, 0);
    applyStimulus(1, 32'h100, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ctr2Taken", bRespTaken, 1);
    checkOutput("modelCtr2", phtB[0], 2);
    repeat (3) applyStimulus(0, 0, 1, 32'h100, 4'h0, 0);
    applyStimulus(1, 32'h100, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ctr0Taken", bRespTaken, 0);
    checkOutput("modelCtr0", phtB[0], 0);
    applyStimulus(0, 0, 1, 32'h100, 4'h0, 0);
    applyStimulus(0, 0, 1, 32'h100, 4'h0, 1);
    applyStimulus(1, 32'h100, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("noWrapTaken", bRespTaken, 0);
    checkOutput("modelNoWrap", phtB[0], 1);

    // History shift: T,T,N,T gives 4'b1101.
    applyStimulus(0, 0, 1, 32'h3C, 4'h0, 1);
    applyStimulus(0, 0, 1, 32'h3C, 4'h0, 1);
    applyStimulus(0, 0, 1, 32'h3C, 4'h0, 0);
    applyStimulus(0, 0, 1, 32'h3C, 4'h0, 1);
    applyStimulus(1, 32'h3C, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ghr1101Gs", gRespHist, 13);
    checkOutput("ghr1101Bim", bRespHist, 13);
    checkOutput("modelGhr", modelGhr, 13);

    // gshare aliasing with history 0101: pc 0x0 maps to idx 5 and pc 0x14 maps to idx 0.
    applyStimulus(0, 0, 1, 32'h3C, 4'h0, 0);
    applyStimulus(0, 0, 1, 32'h3C, 4'h0, 1);
    applyStimulus(0, 0, 1, 32'h3C, 4'h0, 0);
    applyStimulus(0, 0, 1, 32'h3C, 4'h0, 1);
    applyStimulus(0, 0, 1, 32'h0, 4'h5, 1);
    applyStimulus(0, 0, 1, 32'h0, 4'h5, 1);
    applyStimulus(0, 0, 1, 32'h3C, 4'h0, 0);
    applyStimulus(0, 0, 1, 32'h3C, 4'h0, 1);
    applyStimulus(0, 0, 1, 32'h3C, 4'h0, 0);
    applyStimulus(0, 0, 1, 32'h3C, 4'h0, 1);
    applyStimulus(1, 32'h0, 0, 0, 0, 0);
    applyStimulus(1, 32'h14, 0, 0, 0, 0);
    checkOutput("gsIdx5Taken", gRespTaken, 1);
    checkOutput("gsIdx5Hist", gRespHist, 5);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("gsIdx0Taken", gRespTaken, 0);
    checkOutput("gsIdx0Hist", gRespHist, 5);
    checkOutput("modelGsIdx5", phtG[5], 3);

    // Request and update to the same entry on one edge: the response shows the old counter.
    applyStimulus(1, 32'h28, 1, 32'h28, 4'h5, 1);
    applyStimulus(1, 32'h28, 0, 0, 0, 0);
    checkOutput("simulOld", bRespTaken, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("simulNew", bRespTaken, 1);

    // Reset in the cycle after an accepted request.
    applyStimulus(1, 32'h100, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("preRstVal", bRespVal, 1);
    checkOutput("preRstTaken", bRespTaken, 1);
    rstN = 1'b0;
    #1;
    checkOutput("midRstVal", bRespVal, 0);
    checkOutput("midRstHist", gRespHist, 0);
    checkOutput("midRstBusy", gInitBusy, 1);
    repeat (3) @(negedge clk);
    #1;
    rstN = 1'b1;
    cnt = 0;
    while (gInitBusy && cnt < 40) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      cnt++;
    end
    checkOutput("reinitCycles", cnt, 16);
    applyStimulus(1, 32'h100, 0, 0, 0, 0);
    applyStimulus(1, 32'h0, 0, 0, 0, 0);
    checkOutput("reinitBimTaken", bRespTaken, 0);
    checkOutput("reinitGhr", bRespHist, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("reinitGsTaken", gRespTaken, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
